// File: rtl/tcm_mem_top.sv
// tcm_mem_top - parametrised tightly-coupled memory (instruction or data).
//
// Single-port req/gnt memory with byte-masked writes, a READ_LATENCY-deep
// response pipeline, an address range check with an error response and a
// hardware zero-clear sweep that runs after reset or when clear_i is pulsed.
//
// Parameters:
//   DATA_WIDTH   word width in bits (multiple of 8)
//   DEPTH        number of words (need not be a power of two)
//   READ_LATENCY response latency in cycles, 1..4
//   ADDR_WIDTH   derived word-address width, $clog2(DEPTH)
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   req_i / gnt_o    request / grant (accepted when both are 1)
//   we_i             1 = write, 0 = read
//   addr_i           word address
//   wdata_i, wmask_i write data and byte-lane enables
//   rdata_o          response data (holds last response while rvalid_o=0)
//   rvalid_o         one-cycle response pulse
//   rerr_o           response error, qualified by rvalid_o
//   clear_i          request a full zero-clear (ignored during a sweep)
//   busy_o           clear sweep in progress
//
// Optional feature macro: TCM_WRITE_RSP_EN - when defined, every accepted
// write also returns a response (rdata_o=0, rerr_o=1 when out of range).

module tcm_mem_top #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_WIDTH   = $clog2(DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wmask_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    rvalid_o,
  output logic                    rerr_o,
  input  logic                    clear_i,
  output logic                    busy_o
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   r_ram_q;

  logic                    w_acc;
  logic                    w_in_range;
  logic                    w_rd;
  logic                    w_wr;
  logic                    w_rsp_vld;
  logic                    w_rsp_zero;

  assign gnt_o  = (r_state == ST_READY);
  assign busy_o = (r_state == ST_CLEAR);

  assign w_acc      = req_i & gnt_o;
  assign w_in_range = (32'(addr_i) < 32'(DEPTH));
  assign w_rd       = w_acc & ~we_i & w_in_range;
  assign w_wr       = w_acc & we_i & w_in_range;
  // Error and write responses carry zero data instead of array contents.
  assign w_rsp_zero = we_i | ~w_in_range;

`ifdef TCM_WRITE_RSP_EN
  assign w_rsp_vld = w_acc;
`else
  assign w_rsp_vld = w_acc & ~we_i;
`endif

  // Clear FSM: the counter walks 0..DEPTH-1 and stops there, so it never
  // addresses words beyond the array even when DEPTH is not a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_cnt == LAST_ADDR) begin
            r_state <= ST_READY;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (clear_i) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  // Storage array with registered read. No reset so it maps onto block RAM;
  // the sweep and the request port are mutually exclusive by state.
  always_ff @(posedge clk_i) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (wmask_i[b]) begin
          r_mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (w_rd) begin
      r_ram_q <= r_mem[addr_i];
    end
  end

  // Response pipeline. Stage 0 lines up with the registered RAM read;
  // later stages only move data when a valid response passes through.
  logic                  r_vld0;
  logic                  r_err0;
  logic                  r_zero0;
  logic [READ_LATENCY-1:0] w_vld;
  logic [READ_LATENCY-1:0] w_err;
  logic [DATA_WIDTH-1:0]   w_dat [READ_LATENCY];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld0  <= 1'b0;
      r_err0  <= 1'b0;
      r_zero0 <= 1'b0;
    end else begin
      r_vld0  <= w_rsp_vld;
      r_err0  <= w_rsp_vld & ~w_in_range;
      r_zero0 <= w_rsp_zero;
    end
  end

  assign w_vld[0] = r_vld0;
  assign w_err[0] = r_err0;
  assign w_dat[0] = r_zero0 ? '0 : r_ram_q;

  genvar gi;
  generate
    for (gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
      logic                  r_vld;
      logic                  r_err;
      logic [DATA_WIDTH-1:0] r_dat;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_vld <= 1'b0;
          r_err <= 1'b0;
          r_dat <= '0;
        end else begin
          r_vld <= w_vld[gi-1];
          r_err <= w_err[gi-1];
          if (w_vld[gi-1]) begin
            r_dat <= w_dat[gi-1];
          end
        end
      end

      assign w_vld[gi] = r_vld;
      assign w_err[gi] = r_err;
      assign w_dat[gi] = r_dat;
    end
  endgenerate

  // Last delivered value, so rdata_o holds steady between responses and
  // reads 0 straight out of reset.
  logic [DATA_WIDTH-1:0] r_last;
  logic [DATA_WIDTH-1:0] w_fin;

  assign w_fin    = w_dat[READ_LATENCY-1];
  assign rvalid_o = w_vld[READ_LATENCY-1];
  assign rerr_o   = w_err[READ_LATENCY-1];
  assign rdata_o  = rvalid_o ? w_fin : r_last;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last <= '0;
    end else if (rvalid_o) begin
      r_last <= w_fin;
    end
  end

endmodule

// File: tb/tb_tcm_mem_top.sv
// tb_tcm_mem_top - directed self-checking bench for tcm_mem_top.
// DUT built with DEPTH=1000 (non power of two, so out-of-range addresses
// exist) and READ_LATENCY=3. Inputs are driven and outputs sampled on the
// falling edge; responses are collected by a monitor into a queue.

module tb_tcm_mem_top;

  localparam int DW    = 32;
  localparam int DEPTH = 1000;
  localparam int LAT   = 3;
  localparam int AW    = 10;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_i = 1'b0;
  logic          gnt_o;
  logic          we_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [DW-1:0] wdata_i = '0;
  logic [3:0]    wmask_i = '0;
  logic [DW-1:0] rdata_o;
  logic          rvalid_o;
  logic          rerr_o;
  logic          clear_i = 1'b0;
  logic          busy_o;

  tcm_mem_top #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .READ_LATENCY(LAT)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .gnt_o   (gnt_o),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .wmask_i (wmask_i),
    .rdata_o (rdata_o),
    .rvalid_o(rvalid_o),
    .rerr_o  (rerr_o),
    .clear_i (clear_i),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
    int            cyc;
  } rsp_t;

  rsp_t rsp_q[$];

  always @(negedge clk_i) begin
    if (!rst_i && rvalid_o) begin
      rsp_q.push_back('{err: rerr_o, data: rdata_o, cyc: cyc});
      $display("rsp: cyc=%0d err=%0b data=%08h", cyc, rerr_o, rdata_o);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Holds the request for exactly one rising edge, returns on the next falling edge.
  task automatic drive(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [3:0] m, input logic clr);
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = a;
    wdata_i = d;
    wmask_i = m;
    clear_i = clr;
    @(negedge clk_i);
  endtask

  task automatic idle();
    req_i   = 1'b0;
    we_i    = 1'b0;
    wmask_i = '0;
    clear_i = 1'b0;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Counts rising edges until gnt_o is seen high; bounded.
  task automatic wait_gnt(input string tag);
    int n;
    n = 0;
    while (!gnt_o && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, n, DEPTH);
  endtask

  task automatic pop_rsp(input string tag, input logic exp_err, input logic [DW-1:0] exp_data,
                         output int rcyc);
    rsp_t r;
    rcyc = -1;
    check({tag, "_present"}, (rsp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (rsp_q.size() > 0) begin
      r = rsp_q.pop_front();
      check({tag, "_err"}, {31'd0, r.err}, {31'd0, exp_err});
      check({tag, "_data"}, r.data, exp_data);
      rcyc = r.cyc;
    end
  endtask

  initial begin
    int t;
    int rc;
    int rc1;
    int rc2;
    int rc3;

    // Reset values
    wait_n(3);
    check("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
    check("rst_rerr", {31'd0, rerr_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_gnt", {31'd0, gnt_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd1);

    // Initial sweep: gnt_o rises DEPTH edges after deassertion
    rst_i = 1'b0;
    wait_gnt("init_sweep_len");
    check("init_busy_low", {31'd0, busy_o}, 32'd0);

    // Last valid address reads back as cleared
    drive(1'b0, 10'd999, '0, 4'h0, 1'b0);
    idle();
    wait_n(5);
    pop_rsp("rd_last", 1'b0, 32'h0000_0000, rc);

    // Byte-masked overwrite, then read in the following cycle; latency 3
    drive(1'b1, 10'd5, 32'hDEAD_BEEF, 4'hF, 1'b0);
    drive(1'b1, 10'd5, 32'h1122_3344, 4'h5, 1'b0);
    t = cyc;
    drive(1'b0, 10'd5, '0, 4'h0, 1'b0);
    idle();
    wait_n(5);
    pop_rsp("rmw", 1'b0, 32'hDE22_BE44, rc);
    check("rmw_latency", rc - t, LAT);

    // Back-to-back reads: no bubbles, in order
    drive(1'b1, 10'd1, 32'h0000_00A1, 4'hF, 1'b0);
    drive(1'b1, 10'd2, 32'h0000_00A2, 4'hF, 1'b0);
    drive(1'b1, 10'd3, 32'h0000_00A3, 4'hF, 1'b0);
    t = cyc;
    drive(1'b0, 10'd1, '0, 4'h0, 1'b0);
    drive(1'b0, 10'd2, '0, 4'h0, 1'b0);
    drive(1'b0, 10'd3, '0, 4'h0, 1'b0);
    idle();
    wait_n(6);
    pop_rsp("b2b_1", 1'b0, 32'h0000_00A1, rc1);
    pop_rsp("b2b_2", 1'b0, 32'h0000_00A2, rc2);
    pop_rsp("b2b_3", 1'b0, 32'h0000_00A3, rc3);
    check("b2b_lat1", rc1 - t, LAT);
    check("b2b_gap12", rc2 - rc1, 1);
    check("b2b_gap23", rc3 - rc2, 1);
    // rdata_o holds the last response while idle
    check("hold_rvalid", {31'd0, rvalid_o}, 32'd0);
    check("hold_rdata", rdata_o, 32'h0000_00A3);

    // Out-of-range read
    drive(1'b0, 10'd1000, '0, 4'h0, 1'b0);
    idle();
    wait_n(5);
    pop_rsp("oor_rd", 1'b1, 32'h0000_0000, rc);

    // Out-of-range write
    drive(1'b1, 10'd1001, 32'h0000_00FF, 4'hF, 1'b0);
    idle();
    wait_n(5);
`ifdef TCM_WRITE_RSP_EN
    pop_rsp("oor_wr", 1'b1, 32'h0000_0000, rc);
`else
    check("oor_wr_no_rsp", rsp_q.size(), 32'd0);
`endif

    // Zero write mask leaves the word unchanged
    drive(1'b1, 10'd5, 32'hFFFF_FFFF, 4'h0, 1'b0);
`ifdef TCM_WRITE_RSP_EN
    drive(1'b0, 10'd5, '0, 4'h0, 1'b0);
    idle();
    wait_n(5);
    pop_rsp("mask0_wrsp", 1'b0, 32'h0000_0000, rc);
`else
    drive(1'b0, 10'd5, '0, 4'h0, 1'b0);
    idle();
    wait_n(5);
`endif
    pop_rsp("mask0_rd", 1'b0, 32'hDE22_BE44, rc);

    // Clear in the same cycle as a read: read sees pre-clear data
    drive(1'b1, 10'd7, 32'h0000_0077, 4'hF, 1'b0);
`ifdef TCM_WRITE_RSP_EN
    idle();
    wait_n(5);
    rsp_q.delete();
`endif
    drive(1'b0, 10'd7, '0, 4'h0, 1'b1);
    idle();
    check("clr_busy", {31'd0, busy_o}, 32'd1);
    check("clr_gnt", {31'd0, gnt_o}, 32'd0);
    wait_gnt("clr_sweep_len");
    pop_rsp("clr_rd", 1'b0, 32'h0000_0077, rc);
    drive(1'b0, 10'd7, '0, 4'h0, 1'b0);
    drive(1'b0, 10'd5, '0, 4'h0, 1'b0);
    idle();
    wait_n(5);
    pop_rsp("after_clr_a7", 1'b0, 32'h0000_0000, rc);
    pop_rsp("after_clr_a5", 1'b0, 32'h0000_0000, rc);

    // Reset mid-sweep with a response still in flight
    drive(1'b1, 10'd2, 32'h0000_00A2, 4'hF, 1'b0);
    idle();
    wait_n(5);
    rsp_q.delete();
    drive(1'b0, 10'd2, '0, 4'h0, 1'b1);
    idle();
    wait_n(1);
    rst_i = 1'b1;
    #1;
    check("midrst_rvalid", {31'd0, rvalid_o}, 32'd0);
    check("midrst_rdata", rdata_o, 32'd0);
    check("midrst_busy", {31'd0, busy_o}, 32'd1);
    check("midrst_gnt", {31'd0, gnt_o}, 32'd0);
    wait_n(3);
    rst_i = 1'b0;
    wait_gnt("midrst_sweep_len");
    check("midrst_flushed", rsp_q.size(), 32'd0);
    drive(1'b0, 10'd2, '0, 4'h0, 1'b0);
    idle();
    wait_n(5);
    pop_rsp("midrst_a2", 1'b0, 32'h0000_0000, rc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tcm_mem_top.md
# tcm_mem_top

Parametrised tightly-coupled memory for instruction or data use, successor to the fixed 4 KiB instruction-memory wrapper. It provides a single-port req/gnt interface with byte-masked writes, a configurable read-latency pipeline, address range checking with an error response, and a hardware zero-clear sweep after reset or on request. It sits directly on the core's instruction or data fetch port and uses a behavioural storage array, with no hard SRAM macro.

## Interface
- DATA_WIDTH, 32: word width in bits; a multiple of 8.
- DEPTH, 1024: number of words; need not be a power of two.
- READ_LATENCY, 1: response latency in cycles, legal range 1..4.
- ADDR_WIDTH, $clog2(DEPTH): derived word-address width; not overridden.
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  1  request valid.
- gnt_o  out  1  grant; a request is accepted on an edge where req_i and gnt_o are both 1.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_WIDTH  word address.
- wdata_i  in  DATA_WIDTH  write data.
- wmask_i  in  DATA_WIDTH/8  byte-lane write enables.
- rdata_o  out  DATA_WIDTH  response data.
- rvalid_o  out  1  response valid; one-cycle pulse per response.
- rerr_o  out  1  response error; qualified by rvalid_o.
- clear_i  in  1  request a full zero-clear of the array.
- busy_o  out  1  a clear sweep is in progress.

## Operation
- FSM states are CLEAR and READY.
- Reset enters CLEAR with clear counter 0.
- In CLEAR:
  - One word per cycle is written to zero at the counter address; the counter increments.
  - After address DEPTH-1 is written, the FSM moves to READY.
- In READY, clear_i=1 moves the FSM to CLEAR at the next edge with the counter at 0.
- clear_i is ignored while in CLEAR.
- gnt_o = (state == READY). It is combinational from the state only and never depends on req_i.
- busy_o = (state == CLEAR).
- Accepted read, addr_i < DEPTH: the word is read and the response is rerr_o=0 with the stored data.
- Accepted read, addr_i >= DEPTH: the array is not accessed; the response is rerr_o=1 with rdata_o=0.
- Accepted write, addr_i < DEPTH: byte b is written with wdata_i[8b+7:8b] for every wmask_i[b]=1; other bytes are unchanged.
  - wmask_i=0 is accepted and leaves the array unchanged.
- Accepted write, addr_i >= DEPTH: the array is not modified.
- Responses return strictly in acceptance order through a READ_LATENCY-deep valid/err/data pipeline. Throughput is one request per cycle.
- rdata_o holds the last response value while rvalid_o=0.

## Timing
- Reset values: rvalid_o=0, rerr_o=0, rdata_o=0, gnt_o=0, busy_o=1; the response pipeline is flushed.
- Initial clear: gnt_o first rises DEPTH cycles after reset deasserts (first edge after deassert writes address 0).
- Response timing: a request accepted at edge k produces a response (rvalid_o, rerr_o, rdata_o) that is valid after edge k+READ_LATENCY-1 and sampled at edge k+READ_LATENCY.
  - For READ_LATENCY=1, rvalid_o is high in the cycle right after acceptance.
- Reading an address in the cycle after it was written returns the new data; the write is committed at its acceptance edge.
- A request in the same cycle as clear_i (state READY) is accepted and completes normally.
  - A read of that request returns the pre-clear data.
  - The sweep starts on the next edge.
- Responses already in the pipeline when CLEAR is entered still complete; the clear never drops an accepted request.
- Reset asserted mid-sweep or mid-pipeline: all outputs take their reset values immediately. The sweep restarts from address 0 after deassertion.
- The counter is ADDR_WIDTH bits wide and ends at DEPTH-1; it never wraps into addresses >= DEPTH.

## Configuration
- TCM_WRITE_RSP_EN defined:
  - Every accepted write also produces a response READ_LATENCY cycles later, with rvalid_o=1 and rdata_o=0.
  - rerr_o=1 if addr_i >= DEPTH, otherwise 0.
- Undefined:
  - Writes produce no response; rvalid_o stays 0 for write slots.
  - Out-of-range writes are dropped silently.

## Test plan
- Reset, DEPTH=1024: busy_o=1 and gnt_o=0 for exactly 1024 cycles after deassert, then gnt_o=1. A read of address 0x3FF then returns 0x00000000 with rerr_o=0.
- READ_LATENCY=3: write 0xDEADBEEF to address 5 with wmask 0xF. Then write 0x11223344 to address 5 with wmask 0x5. A read of address 5 returns 0xDE22BE44 with rvalid_o exactly 3 cycles after acceptance.
- Back-to-back reads of addresses 1, 2, 3 on consecutive cycles (array preloaded with 0xA1, 0xA2, 0xA3): three consecutive rvalid_o cycles in order with no bubbles.
- DEPTH=1000:
  - A read of address 1000 gives rerr_o=1 with rdata_o=0.
  - A write of 0xFF to address 1001 leaves the array unchanged.
  - With TCM_WRITE_RSP_EN that write gives an error response; without it, no rvalid_o.
- clear_i pulsed in the same cycle as a read of address 7 (value 0x77): the read returns 0x77 and busy_o rises next cycle. After 1024 cycles a read of address 7 returns 0.
- Reset asserted mid-sweep at counter 500: rvalid_o=0 immediately. After deassert, gnt_o stays 0 for a full 1024 cycles.
